// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipelined control unit.
// Contents: opcode/funct encodings, ALUOp encodings and the control bundle
// that the decoder produces and the ID/EX register stores.
package pipe_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_JALR  = 6'b001001;

    // Native ALUOp width inside the bundle; the top zero-extends to ALUOP_W.
    localparam int CTRL_ALUOP_W = 2;

    localparam logic [CTRL_ALUOP_W-1:0] ALU_ADD   = 2'b00;
    localparam logic [CTRL_ALUOP_W-1:0] ALU_RTYPE = 2'b10;
    localparam logic [CTRL_ALUOP_W-1:0] ALU_IMM   = 2'b11;

    typedef struct packed {
        logic                    reg_dst;
        logic                    alu_src;
        logic                    mem_to_reg;
        logic                    reg_write;
        logic                    mem_read;
        logic                    mem_write;
        logic                    branch;
        logic                    jump;
        logic                    link;
        logic [CTRL_ALUOP_W-1:0] alu_op;
    } ctrl_bundle_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational ID-stage decoder.
// Ports:
//   id_valid_i  - ID holds a real instruction (otherwise NOP bundle)
//   op_code_i   - instruction [31:26]
//   funct_i     - instruction [5:0]
//   ctrl_o      - decoded control bundle
//   uses_rt_o   - instruction reads rt as a source (for load-use compare)
module ctrl_decode
    import pipe_ctrl_pkg::*;
(
    input  logic         id_valid_i,
    input  logic [5:0]   op_code_i,
    input  logic [5:0]   funct_i,
    output ctrl_bundle_t ctrl_o,
    output logic         uses_rt_o
);

    always_comb begin
        ctrl_o    = '0;
        uses_rt_o = 1'b0;
        if (id_valid_i) begin
            case (op_code_i)
                OP_RTYPE: begin
                    if (funct_i == FN_JR) begin
                        ctrl_o.branch = 1'b1;
                        ctrl_o.jump   = 1'b1;
                    end else if (funct_i == FN_JALR) begin
                        ctrl_o.branch    = 1'b1;
                        ctrl_o.jump      = 1'b1;
                        ctrl_o.link      = 1'b1;
                        ctrl_o.reg_write = 1'b1;
                        ctrl_o.reg_dst   = 1'b1;
                    end else begin
                        ctrl_o.reg_dst   = 1'b1;
                        ctrl_o.reg_write = 1'b1;
                        ctrl_o.alu_op    = ALU_RTYPE;
                        uses_rt_o        = 1'b1;
                    end
                end
                OP_LB, OP_LH, OP_LW: begin
                    ctrl_o.alu_src    = 1'b1;
                    ctrl_o.mem_read   = 1'b1;
                    ctrl_o.reg_write  = 1'b1;
                    ctrl_o.mem_to_reg = 1'b1;
                    ctrl_o.alu_op     = ALU_ADD;
                end
                OP_SB, OP_SH, OP_SW: begin
                    ctrl_o.alu_src   = 1'b1;
                    ctrl_o.mem_write = 1'b1;
                    uses_rt_o        = 1'b1;
                end
                OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: begin
                    ctrl_o.alu_src   = 1'b1;
                    ctrl_o.reg_write = 1'b1;
                    ctrl_o.alu_op    = ALU_IMM;
                end
                OP_BEQ, OP_BNE: begin
                    ctrl_o.branch = 1'b1;
                    uses_rt_o     = 1'b1;
                end
                OP_J: begin
                    ctrl_o.branch = 1'b1;
                    ctrl_o.jump   = 1'b1;
                end
                OP_JAL: begin
                    ctrl_o.branch    = 1'b1;
                    ctrl_o.jump      = 1'b1;
                    ctrl_o.link      = 1'b1;
                    ctrl_o.reg_write = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/control_unit_pipe.sv
// Pipelined control unit: ID decode registered into the ID/EX stage, with
// load-use hazard detection, external stall/flush and a branch-shadow
// down-counter that inserts bubbles after a branch/jump enters EX.
// Ports:
//   clk, reset          - pipeline clock, async active-high reset
//   id_valid, op_code,
//   funct, id_rs, id_rt - ID-stage instruction fields
//   stall_ext           - hold EX register and shadow counter
//   flush               - kill ID instruction, bubble into EX
//   ex_*                - registered EX-stage controls and rt
//   hazard_stall        - combinational PC / IF-ID freeze request
//   shadow_active       - shadow counter non-zero
module control_unit_pipe
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW        = 5,
    parameter int ALUOP_W       = 2,
    parameter int BRANCH_SHADOW = 1,
    parameter int LINK_REG      = 31
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_valid,
    input  logic [5:0]         op_code,
    input  logic [5:0]         funct,
    input  logic [REG_AW-1:0]  id_rs,
    input  logic [REG_AW-1:0]  id_rt,
    input  logic               stall_ext,
    input  logic               flush,
    output logic               ex_reg_dst,
    output logic               ex_alu_src,
    output logic               ex_mem_to_reg,
    output logic               ex_reg_write,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               ex_branch,
    output logic               ex_jump,
    output logic               ex_link,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic [REG_AW-1:0]  ex_rt,
    output logic               hazard_stall,
    output logic               shadow_active
);

    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] SHADOW_INIT = CNT_W'(BRANCH_SHADOW);

    ctrl_bundle_t      dec_ctrl;
    logic              uses_rt;
    ctrl_bundle_t      ex_q, ex_d;
    logic [REG_AW-1:0] ex_rt_q, ex_rt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // The JAL destination is substituted in EX; the value travels with the
    // parameter set so both stages agree on it.
    logic [REG_AW-1:0] unused_link_reg;
    assign unused_link_reg = REG_AW'(LINK_REG);

    ctrl_decode u_decode (
        .id_valid_i (id_valid),
        .op_code_i  (op_code),
        .funct_i    (funct),
        .ctrl_o     (dec_ctrl),
        .uses_rt_o  (uses_rt)
    );

    // A load to $0 never creates a dependency; flush kills the consumer.
    assign hazard_stall = ex_q.mem_read & (ex_rt_q != '0)
                        & ((ex_rt_q == id_rs) | (uses_rt & (ex_rt_q == id_rt)))
                        & id_valid & ~flush;

    always_comb begin
        ex_d    = ex_q;
        ex_rt_d = ex_rt_q;
        cnt_d   = cnt_q;
        if (flush) begin
            ex_d    = '0;
            ex_rt_d = '0;
            cnt_d   = '0;
        end else if (stall_ext) begin
            // hold everything
        end else if (cnt_q != '0) begin
            ex_d    = '0;
            ex_rt_d = '0;
            cnt_d   = cnt_q - CNT_W'(1);
        end else if (hazard_stall) begin
            ex_d    = '0;
            ex_rt_d = '0;
        end else begin
            ex_d    = dec_ctrl;
            ex_rt_d = id_rt;
            if (dec_ctrl.branch) begin
                cnt_d = SHADOW_INIT;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q    <= '0;
            ex_rt_q <= '0;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            ex_rt_q <= ex_rt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_reg_dst    = ex_q.reg_dst;
    assign ex_alu_src    = ex_q.alu_src;
    assign ex_mem_to_reg = ex_q.mem_to_reg;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_branch     = ex_q.branch;
    assign ex_jump       = ex_q.jump;
    assign ex_link       = ex_q.link;
    assign ex_alu_op     = ALUOP_W'(ex_q.alu_op);
    assign ex_rt         = ex_rt_q;
    assign shadow_active = (cnt_q != '0);

endmodule

// File: doc/control_unit_pipe.md
Name: control_unit_pipe

Overview:
- Parametrised successor to the single-cycle opcode decoder: decodes op_code/funct in ID and registers the control bundle into the ID/EX stage.
- Adds load-use hazard detection, external stall and flush, a branch-shadow bubble counter, and JAL/JALR link write-back control.
- Sits between the IF/ID register and the EX stage. It drives EX-stage controls and the PC/IF-ID hold request.

Parameters:
- REG_AW, 5, register-address width (rs/rt/rd fields).
- ALUOP_W, 2, ALUOp field width. Values 00 add, 10 R-type funct, 11 immediate group; values at or above 4 are reserved.
- BRANCH_SHADOW, 1, bubbles inserted after a branch/jump enters EX. Range 0..7.
- LINK_REG, 31, destination register written by JAL.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- op_code  in  6  instruction [31:26].
- funct  in  6  instruction [5:0].
- id_rs  in  REG_AW  ID source register 1.
- id_rt  in  REG_AW  ID source register 2.
- stall_ext  in  1  downstream stall; hold EX register and counter.
- flush  in  1  kill the ID instruction; load a bubble into EX.
- ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_link  out  1 each  registered controls.
- ex_alu_op  out  ALUOP_W  registered ALUOp.
- ex_rt  out  REG_AW  registered id_rt, used for hazard compare.
- hazard_stall  out  1  combinational; freeze PC and IF/ID.
- shadow_active  out  1  high while the branch-shadow counter is non-zero.

Behaviour:
- Decode (combinational, internal):
  - R-type (op 000000, funct not 001000/001001): reg_dst=1, reg_write=1, alu_op=10.
  - JR (funct 001000): branch=1, jump=1.
  - JALR (funct 001001): branch=1, jump=1, link=1, reg_write=1, reg_dst=1.
  - LB/LH/LW (100000/100001/100011): alu_src=1, mem_read=1, reg_write=1, mem_to_reg=1, alu_op=00.
  - SB/SH/SW (101000/101001/101011): alu_src=1, mem_write=1.
  - ADDI/ANDI/ORI/XORI/SLTI (001000/001100/001101/001110/001010): alu_src=1, reg_write=1, alu_op=11.
  - BEQ/BNE (000100/000101): branch=1.
  - J (000010): branch=1, jump=1.
  - JAL (000011): branch=1, jump=1, link=1, reg_write=1. EX substitutes LINK_REG.
  - Any other opcode, or id_valid=0: all zero (NOP).
- uses_rt = 1 for R-type, stores, BEQ and BNE; 0 otherwise.
- Load-use hazard: hazard_stall = ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (uses_rt & ex_rt == id_rt)) & id_valid & ~flush.
- EX register update on each clk rising edge, first matching rule wins:
  1. flush=1: bubble (all controls 0, ex_rt=0). Counter cleared to 0.
  2. stall_ext=1: hold all EX outputs and the counter.
  3. Counter > 0: bubble; counter decrements by 1.
  4. hazard_stall=1: bubble.
  5. Otherwise: load decoded controls and id_rt.
     - If the loaded instruction has branch=1, counter = BRANCH_SHADOW.
- Latency: decode to EX outputs is 1 cycle. hazard_stall has 0-cycle latency.
- A load-use pair costs exactly one bubble. After the bubble, ex_mem_read=0, so the hazard clears.
- Bubble during shadow: hazard_stall may still assert, but the counter rule already forces the bubble. The ID instruction is held and re-evaluated.
- shadow_active = (counter != 0).
- Counter width: 3 bits. With BRANCH_SHADOW=0, no bubbles are inserted and shadow_active stays 0.
- Reset (asynchronous, any time including mid-shadow or mid-stall): all ex_* outputs 0, ex_rt=0, counter=0, shadow_active=0.
- hazard_stall is 0 while reset is held, because ex_mem_read=0.
- No initial blocks. Every output is registered except hazard_stall.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - opcode and funct localparams (OP_RTYPE, OP_LW, ..., FN_JR, FN_JALR);
  - ALUOp encodings (ALU_ADD=00, ALU_RTYPE=10, ALU_IMM=11);
  - a ctrl_bundle_t struct (reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump, link, alu_op).
- One sub-module: ctrl_decode (purely combinational, op_code/funct/id_valid -> ctrl_bundle_t, uses_rt).
- The top holds the EX register, hazard logic and shadow counter.

Test Plan:
- Reset mid-shadow: BEQ loaded, reset asserted asynchronously between edges -> all outputs 0 immediately; shadow_active=0.
- Load-use: LW $8 loaded into EX, then ID = ADD rs=8 -> hazard_stall=1, next cycle EX all-zero bubble; the following cycle ex_reg_write=1, ex_alu_op=10.
- No false hazard: LW to $0 in EX, ID uses $0 -> hazard_stall=0. Also ADDI rt=8 after LW $8 -> stall only via rs match; rs=9 gives no stall.
- Branch shadow with BRANCH_SHADOW=2: J enters EX (ex_jump=1) -> next 2 cycles bubbles with shadow_active=1 -> third cycle loads the ID instruction.
- Priority: flush=1, stall_ext=1 and hazard condition all in one cycle -> EX becomes bubble, counter 0, hazard_stall=0. stall_ext alone for 3 cycles with SW in EX -> ex_mem_write held at 1 throughout.
- Link decode: JAL -> ex_link=1, ex_reg_write=1, ex_branch=1. JALR -> also ex_reg_dst=1. Opcode 111111 -> all controls 0.
